// File: rtl/reduccion_signo.sv
// reduccion_signo: narrows signed 32-bit words to signed 16 bits.
// It flags words that do not fit, queues results in a 2-entry FIFO with a
// valid/ready handshake on both sides, and counts overflows with saturation.
// Optional build macro REDUCCION_SATURACION_EN clamps overflowing words to
// 16'h7FFF or 16'h8000. Without the macro, out_data keeps the low halfword.
module reduccion_signo #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [15:0] head_data;
  logic        head_ovf;
  logic [15:0] tail_data;
  logic        tail_ovf;

  logic [15:0] nar_data;
  logic        nar_ovf;
  logic        accept;
  logic        consume;

  // The word fits in 16 bits only when bits 31..15 are a pure sign extension.
  always_comb begin
    nar_ovf  = !((&in_data[31:15]) || (~|in_data[31:15]));
    nar_data = in_data[15:0];
`ifdef REDUCCION_SATURACION_EN
    if (nar_ovf) begin
      nar_data = in_data[31] ? 16'h8000 : 16'h7FFF;
    end
`endif
  end

  // Handshake flags come from registered state, so out_ready never reaches in_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  assign out_data  = head_data;
  assign out_ovf   = head_ovf;

  // Occupancy FSM with head/tail storage and the saturating overflow counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head_data <= 16'h0000;
      head_ovf  <= 1'b0;
      tail_data <= 16'h0000;
      tail_ovf  <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (accept && nar_ovf && (ovf_count != '1)) begin
        ovf_count <= ovf_count + CNT_ONE;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            head_data <= nar_data;
            head_ovf  <= nar_ovf;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_data <= nar_data;
            head_ovf  <= nar_ovf;
          end else if (accept) begin
            tail_data <= nar_data;
            tail_ovf  <= nar_ovf;
            state     <= TWO;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            head_data <= tail_data;
            head_ovf  <= tail_ovf;
            state     <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduccion_signo.sv
// tb_reduccion_signo: directed tests for reduccion_signo.
// A second instance with CNT_W=2 exercises counter saturation.
// Expected data values follow REDUCCION_SATURACION_EN when it is defined.
module tb_reduccion_signo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [7:0]  ovf_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [15:0] out_data2;
  logic        out_ovf2;
  logic [1:0]  ovf_count2;

  int passed;
  int total;

`ifdef REDUCCION_SATURACION_EN
  localparam logic [15:0] EXP_00012345 = 16'h7FFF;
  localparam logic [15:0] EXP_FFFE1234 = 16'h8000;
  localparam logic [15:0] EXP_00008000 = 16'h7FFF;
`else
  localparam logic [15:0] EXP_00012345 = 16'h2345;
  localparam logic [15:0] EXP_FFFE1234 = 16'h1234;
  localparam logic [15:0] EXP_00008000 = 16'h8000;
`endif

  reduccion_signo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .ovf_count (ovf_count)
  );

  reduccion_signo #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready2),
    .out_valid (out_valid2),
    .out_data  (out_data2),
    .out_ovf   (out_ovf2),
    .out_ready (out_ready),
    .ovf_count (ovf_count2)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the three stimulus inputs together.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_data !== 16'h0000) $display("[TB] FAIL reset_out_data got %h want 0000", out_data); else passed++;
    total++; if (out_ovf !== 1'b0) $display("[TB] FAIL reset_out_ovf got %b want 0", out_ovf); else passed++;
    total++; if (ovf_count !== 8'd0) $display("[TB] FAIL reset_ovf_count got %0d want 0", ovf_count); else passed++;
  endtask

  task automatic test_sign_extended();
    applyStimulus(1'b1, 32'hFFFF8000, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL sext_out_valid got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 16'h8000) $display("[TB] FAIL sext_out_data got %h want 8000", out_data); else passed++;
    total++; if (out_ovf !== 1'b0) $display("[TB] FAIL sext_out_ovf got %b want 0", out_ovf); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL sext_drained got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_overflow();
    applyStimulus(1'b1, 32'h00012345, 1'b0);
    tick();
    total++; if (out_ovf !== 1'b1) $display("[TB] FAIL ovf_pos_flag got %b want 1", out_ovf); else passed++;
    total++; if (out_data !== EXP_00012345) $display("[TB] FAIL ovf_pos_data got %h want %h", out_data, EXP_00012345); else passed++;
    total++; if (ovf_count !== 8'd1) $display("[TB] FAIL ovf_pos_count got %0d want 1", ovf_count); else passed++;
    applyStimulus(1'b1, 32'hFFFE1234, 1'b1);
    tick();
    total++; if (out_data !== EXP_FFFE1234) $display("[TB] FAIL ovf_neg_data got %h want %h", out_data, EXP_FFFE1234); else passed++;
    total++; if (out_ovf !== 1'b1) $display("[TB] FAIL ovf_neg_flag got %b want 1", out_ovf); else passed++;
    total++; if (ovf_count !== 8'd2) $display("[TB] FAIL ovf_neg_count got %0d want 2", ovf_count); else passed++;
    applyStimulus(1'b1, 32'h00007FFF, 1'b1);
    tick();
    total++; if (out_data !== 16'h7FFF) $display("[TB] FAIL max_pos_data got %h want 7fff", out_data); else passed++;
    total++; if (out_ovf !== 1'b0) $display("[TB] FAIL max_pos_flag got %b want 0", out_ovf); else passed++;
    total++; if (ovf_count !== 8'd2) $display("[TB] FAIL max_pos_count got %0d want 2", ovf_count); else passed++;
    applyStimulus(1'b1, 32'h00008000, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    total++; if (out_data !== EXP_00008000) $display("[TB] FAIL just_over_data got %h want %h", out_data, EXP_00008000); else passed++;
    total++; if (out_ovf !== 1'b1) $display("[TB] FAIL just_over_flag got %b want 1", out_ovf); else passed++;
    total++; if (ovf_count !== 8'd3) $display("[TB] FAIL just_over_count got %0d want 3", ovf_count); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL ovf_drained got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_pressure();
    applyStimulus(1'b1, 32'd1, 1'b0);
    tick();
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_one got %b want 1", in_ready); else passed++;
    applyStimulus(1'b1, 32'd2, 1'b0);
    tick();
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_two got %b want 0", in_ready); else passed++;
    applyStimulus(1'b1, 32'd3, 1'b0);
    tick();
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_held_ready got %b want 0", in_ready); else passed++;
    total++; if (out_data !== 16'd1) $display("[TB] FAIL bp_held_data got %h want 0001", out_data); else passed++;
    total++; if (ovf_count !== 8'd3) $display("[TB] FAIL bp_held_count got %0d want 3", ovf_count); else passed++;
    applyStimulus(1'b1, 32'd3, 1'b1);
    tick();
    total++; if (out_data !== 16'd2) $display("[TB] FAIL bp_drain2_data got %h want 0002", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_drain2_ready got %b want 1", in_ready); else passed++;
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    total++; if (out_data !== 16'd3) $display("[TB] FAIL bp_drain3_data got %h want 0003", out_data); else passed++;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_drain3_valid got %b want 1", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_empty got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_streaming();
    applyStimulus(1'b1, 32'h100, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h101 + i, 1'b1);
      tick();
      total++;
      if (out_data !== 16'(16'h101 + i) || out_valid !== 1'b1 || in_ready !== 1'b1)
        $display("[TB] FAIL stream_%0d got data=%h valid=%b ready=%b want data=%h valid=1 ready=1",
                 i, out_data, out_valid, in_ready, 16'(16'h101 + i));
      else passed++;
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL stream_drained got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_counter_saturation();
    logic [1:0] exp2 [5];
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h00010000 + i, 1'b1);
      tick();
      total++;
      if (ovf_count2 !== exp2[i])
        $display("[TB] FAIL sat2_count_%0d got %0d want %0d", i, ovf_count2, exp2[i]);
      else passed++;
      total++;
      if (ovf_count !== 8'(i + 1))
        $display("[TB] FAIL sat8_count_%0d got %0d want %0d", i, ovf_count, i + 1);
      else passed++;
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    applyStimulus(1'b1, 32'h00020000, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00030000, 1'b0);
    tick();
    total++; if (ovf_count !== 8'd2) $display("[TB] FAIL mid_prefill_count got %0d want 2", ovf_count); else passed++;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL mid_prefill_ready got %b want 0", in_ready); else passed++;
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h00050000, 1'b1);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_rst_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_rst_ready got %b want 1", in_ready); else passed++;
    total++; if (ovf_count !== 8'd0) $display("[TB] FAIL mid_rst_count got %0d want 0", ovf_count); else passed++;
    total++; if (out_data !== 16'h0000) $display("[TB] FAIL mid_rst_data got %h want 0000", out_data); else passed++;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_no_stale got %b want 0", out_valid); else passed++;
    applyStimulus(1'b1, 32'h00000042, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    total++; if (out_data !== 16'h0042) $display("[TB] FAIL mid_fresh_data got %h want 0042", out_data); else passed++;
    total++; if (out_ovf !== 1'b0) $display("[TB] FAIL mid_fresh_ovf got %b want 0", out_ovf); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_fresh_drained got %b want 0", out_valid); else passed++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    test_reset();
    test_sign_extended();
    test_overflow();
    test_back_pressure();
    test_streaming();
    test_counter_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
